// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch PC owner and prefetch FIFO feeding decode
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          pop;
   logic          push;

   // A full queue can still accept a word when the head leaves in the same cycle;
   // a redirect suppresses the push because the fetched word is on the old path.
   assign pop      = if_valid & if_ready;
   assign push     = ~redirect_valid & ((count < FULL_COUNT) | pop);
   assign rom_addr = fetch_pc;
   assign if_valid = (count != '0);
   assign {if_pc, if_instr} = mem[rd_ptr];

   // Entry storage: captures {pc, instr} at the write pointer, cleared on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= {fetch_pc, rom_data};
      end
   end

   // Fetch PC, pointers and occupancy; a redirect flushes and wins over push/pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + AW'(1);
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t sb_q[$];

   always #5 clk = ~clk;

   // ROM: word i holds 0x1000+i, aliasing every 1 KiB
   assign rom_data = 32'h0000_1000 + {24'h0, rom_addr[9:2]};

   instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rom_word(input logic [31:0] pc);
      return 32'h0000_1000 + {24'h0, pc[9:2]};
   endfunction

   task automatic sb_fill(input logic [31:0] start);
      logic [31:0] pc;
      ent_t e;
      sb_q.delete();
      pc = start;
      for (int i = 0; i < 512; i++) begin
         e.pc    = pc;
         e.instr = rom_word(pc);
         sb_q.push_back(e);
         pc = pc + 32'd4;
      end
   endtask

   // Monitor on the falling edge: head must match the expected stream; a handshake
   // consumes it unless a redirect voids it; reset/redirect restart the expectations.
   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         sb_fill(32'h0000_0000);
      end else begin
         if (if_valid) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
               check("head_pc", if_pc, sb_q[0].pc);
               check("head_instr", if_instr, sb_q[0].instr);
            end
         end
         if (redirect_valid) begin
            sb_fill(redirect_pc & 32'hFFFF_FFFC);
         end else if (if_valid && if_ready && sb_q.size() != 0) begin
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      tick();
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
   endtask

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      if_ready       = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_valid", {31'h0, if_valid}, 32'h0);
      check("rst_rom_addr", rom_addr, 32'h0);
      check("rst_instr", if_instr, 32'h0);
      check("rst_pc", if_pc, 32'h0);

      // Fill with decode stalled
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("fill_valid", {31'h0, if_valid}, 32'h1);
      check("fill_instr", if_instr, 32'h1000);
      check("fill_pc", if_pc, 32'h0);
      check("fill_rom_addr", rom_addr, 32'h10);
      for (int i = 0; i < 3; i++) tick();
      check("full_rom_addr_hold", rom_addr, 32'h10);
      check("full_instr_hold", if_instr, 32'h1000);

      // Streaming from reset, one instruction per cycle
      rst_n    = 1'b0;
      if_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         check("stream_valid", {31'h0, if_valid}, 32'h1);
         check("stream_pc", if_pc, 32'(4 * i));
         check("stream_instr", if_instr, 32'h1000 + 32'(i));
         tick();
      end

      // Redirect with unaligned target
      do_redirect(32'h0000_0043);
      check("redir_valid", {31'h0, if_valid}, 32'h0);
      check("redir_rom_addr", rom_addr, 32'h40);
      tick();
      check("redir_head_valid", {31'h0, if_valid}, 32'h1);
      check("redir_head_pc", if_pc, 32'h40);
      check("redir_head_instr", if_instr, 32'h1010);

      // Full queue, pop and redirect in the same cycle
      if_ready = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("full2_rom_addr", rom_addr, 32'h50);
      if_ready = 1'b1;
      do_redirect(32'h0000_0080);
      check("flush_valid", {31'h0, if_valid}, 32'h0);
      check("flush_rom_addr", rom_addr, 32'h80);
      tick();
      check("flush_head_pc", if_pc, 32'h80);
      check("flush_head_instr", if_instr, 32'h1020);

      // Random backpressure; the monitor checks ordering and head stability
      for (int i = 0; i < 200; i++) begin
         if_ready = 1'($urandom_range(0, 1));
         tick();
      end

      // Reset mid-stream with three entries queued
      if_ready = 1'b0;
      do_redirect(32'h0000_0100);
      for (int i = 0; i < 3; i++) tick();
      check("mid_pc_before_rst", if_pc, 32'h100);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'h0, if_valid}, 32'h0);
      check("mid_rst_rom_addr", rom_addr, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_rel_valid", {31'h0, if_valid}, 32'h1);
      check("mid_rel_pc", if_pc, 32'h0);
      check("mid_rel_instr", if_instr, 32'h1000);

      // PC wrap past the top of the address space
      if_ready = 1'b1;
      do_redirect(32'hFFFF_FFF8);
      tick();
      check("wrap_pc0", if_pc, 32'hFFFF_FFF8);
      check("wrap_instr0", if_instr, 32'h10FE);
      tick();
      check("wrap_pc1", if_pc, 32'hFFFF_FFFC);
      check("wrap_instr1", if_instr, 32'h10FF);
      tick();
      check("wrap_pc2", if_pc, 32'h0000_0000);
      check("wrap_instr2", if_instr, 32'h1000);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
